score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper_if.sv | 24 ++
 rtl/score_keeper.sv | 172 +++++++++++++++++
 tb/tb_score_keeper.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_keeper_if.sv
// Signal bundle between the maze game core and the score keeper.
// The game core drives pellet activity and start; the score keeper returns score state.
interface score_keeper_if #(
    parameter int NUM_FOOD = 64
);
    logic                start;
    logic [NUM_FOOD-1:0] points;
    logic [NUM_FOOD-1:0] food_on;
    logic [23:0]         score_bcd;
    logic [23:0]         high_score_bcd;
    logic [3:0]          level;
    logic                level_clear;
    logic                busy;

    modport master (
        output start, points, food_on,
        input  score_bcd, high_score_bcd, level, level_clear, busy
    );

    modport slave (
        input  start, points, food_on,
        output score_bcd, high_score_bcd, level, level_clear, busy
    );
endinterface

// File: rtl/score_keeper.sv
// Pellet credit accumulator with BCD score, high score and level tracking.
// Eaten pellets queue as pending credits that are applied one per cycle.
module score_keeper #(
    parameter int NUM_FOOD     = 64,
    parameter int PELLET_VALUE = 10
) (
    input  logic           frame_clk,
    input  logic           Reset,
    score_keeper_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_CLEARED = 2'd2
    } state_t;

    localparam logic [3:0]  PV_ONES   = 4'(PELLET_VALUE % 10);
    localparam logic [3:0]  PV_TENS   = 4'(PELLET_VALUE / 10);
    localparam logic [23:0] PV_BCD    = {16'h0000, PV_TENS, PV_ONES};
    localparam logic [23:0] SCORE_MAX = 24'h999999;
    localparam logic [8:0]  PEND_MAX  = 9'h1FF;

    function automatic logic [8:0] popcount(input logic [NUM_FOOD-1:0] v);
        logic [8:0] c;
        c = 9'd0;
        for (int i = 0; i < NUM_FOOD; i++) begin
            c = c + {8'd0, v[i]};
        end
        return c;
    endfunction

    // Six-digit BCD addition; bit 24 is the carry out of the top digit.
    function automatic logic [24:0] bcd_add(input logic [23:0] a, input logic [23:0] b);
        logic [24:0] r;
        logic [4:0]  d;
        logic        carry;
        r     = 25'd0;
        carry = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'd0, carry};
            if (d > 5'd9) begin
                d     = d + 5'd6;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            r[i*4 +: 4] = d[3:0];
        end
        r[24] = carry;
        return r;
    endfunction

    function automatic logic bcd_gt(input logic [23:0] a, input logic [23:0] b);
        logic gt;
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            gt      = decided ? gt : (a[i*4 +: 4] > b[i*4 +: 4]);
            decided = decided | (a[i*4 +: 4] != b[i*4 +: 4]);
        end
        return gt;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [8:0]  pending_r, pending_nxt_s;
    logic [23:0] score_r, score_nxt_s;
    logic [23:0] high_r;
    logic [3:0]  level_r, level_nxt_s;
    logic        level_clear_r, level_clear_nxt_s;

    logic [8:0]  pellet_cnt_s;
    logic [9:0]  pending_sum_s;
    logic [24:0] score_add_s;
    logic [23:0] score_inc_s;
    logic        food_empty_s;
    logic        pending_any_s;

    // Datapath helpers shared by the next-state logic.
    always_comb begin
        pellet_cnt_s  = popcount(bus.points);
        pending_any_s = (pending_r != 9'd0);
        food_empty_s  = (bus.food_on == {NUM_FOOD{1'b0}});
        pending_sum_s = {1'b0, pending_r} + {1'b0, pellet_cnt_s} - {9'd0, pending_any_s};
        score_add_s   = bcd_add(score_r, PV_BCD);
        score_inc_s   = score_add_s[24] ? SCORE_MAX : score_add_s[23:0];
    end

    // Next-state and next-value logic for the game FSM.
    always_comb begin
        state_nxt_s       = state_r;
        pending_nxt_s     = pending_r;
        score_nxt_s       = score_r;
        level_nxt_s       = level_r;
        level_clear_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s   = ST_PLAY;
                    score_nxt_s   = 24'h000000;
                    level_nxt_s   = 4'd1;
                    pending_nxt_s = 9'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                pending_nxt_s = (pending_sum_s > {1'b0, PEND_MAX}) ? PEND_MAX : pending_sum_s[8:0];
                if (pending_any_s && (score_r != SCORE_MAX)) begin
                    score_nxt_s = score_inc_s;
                end else begin
                    score_nxt_s = score_r;
                end
                // Pellets eaten in the emptying cycle must be credited before clearing.
                if (food_empty_s && !pending_any_s && (pellet_cnt_s == 9'd0)) begin
                    state_nxt_s       = ST_CLEARED;
                    level_clear_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_PLAY;
                end
            end
            ST_CLEARED: begin
                if (bus.start) begin
                    state_nxt_s   = ST_PLAY;
                    level_nxt_s   = (level_r == 4'd15) ? 4'd1 : (level_r + 4'd1);
                    pending_nxt_s = 9'd0;
                end else begin
                    state_nxt_s = ST_CLEARED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Game state registers.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state_r       <= ST_IDLE;
            pending_r     <= 9'd0;
            score_r       <= 24'h000000;
            level_r       <= 4'd0;
            level_clear_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            pending_r     <= pending_nxt_s;
            score_r       <= score_nxt_s;
            level_r       <= level_nxt_s;
            level_clear_r <= level_clear_nxt_s;
        end
    end

    // High score follows the score one cycle after it is overtaken.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            high_r <= 24'h000000;
        end else if (bcd_gt(score_r, high_r)) begin
            high_r <= score_r;
        end else begin
            high_r <= high_r;
        end
    end

    assign bus.score_bcd      = score_r;
    assign bus.high_score_bcd = high_r;
    assign bus.level          = level_r;
    assign bus.level_clear    = level_clear_r;
    assign bus.busy           = (pending_r != 9'd0);

endmodule

// File: tb/tb_score_keeper.sv
// Randomized scoreboard bench for score_keeper against a decimal reference model.
module tb_score_keeper;

    localparam int NF  = 64;
    localparam int PV  = 10;
    localparam int SPV = 97;

    logic frame_clk = 1'b0;
    logic Reset;
    always #5 frame_clk = ~frame_clk;

    score_keeper_if #(.NUM_FOOD(NF)) bus ();
    score_keeper #(.NUM_FOOD(NF), .PELLET_VALUE(PV)) dut (
        .frame_clk(frame_clk), .Reset(Reset), .bus(bus));

    score_keeper_if #(.NUM_FOOD(4)) sbus ();
    score_keeper #(.NUM_FOOD(4), .PELLET_VALUE(SPV)) sdut (
        .frame_clk(frame_clk), .Reset(Reset), .bus(sbus));

    int checks = 0;
    int errors = 0;

    // Reference model in plain decimal arithmetic.
    int m_state;   // 0 idle, 1 playing, 2 level cleared
    int m_pending, m_score, m_high, m_level;
    logic [23:0] exp_score_q[$];
    logic [23:0] exp_high_q[$];
    int          clr_q[$];

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int x;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [NF-1:0] rand_pts(input int density);
        logic [NF-1:0] p;
        for (int i = 0; i < NF; i++) p[i] = ($urandom_range(density - 1) == 0);
        return p;
    endfunction

    function automatic logic [NF-1:0] rand_food();
        logic [NF-1:0] f;
        for (int i = 0; i < NF; i++) f[i] = $urandom_range(1);
        f[0] = 1'b1;
        return f;
    endfunction

    task automatic credit();
        int n;
        n = m_score + PV;
        if (n > 999999) n = 999999;
        if (n != m_score) begin
            m_score = n;
            exp_score_q.push_back(to_bcd(n));
            if (n > m_high) begin
                m_high = n;
                exp_high_q.push_back(to_bcd(n));
            end
        end
    endtask

    task automatic step(input logic st, input logic [NF-1:0] pts, input logic [NF-1:0] fo);
        int pc;
        bus.start   = st;
        bus.points  = pts;
        bus.food_on = fo;
        pc = $countones(pts);
        if (m_state == 0) begin
            if (st) begin
                m_state = 1; m_score = 0; m_level = 1; m_pending = 0;
            end
        end else if (m_state == 1) begin
            if (fo == '0 && m_pending == 0 && pc == 0) begin
                m_state = 2;
                clr_q.push_back(m_level);
            end
            if (m_pending > 0) begin
                credit();
                m_pending = m_pending - 1;
            end
            m_pending = m_pending + pc;
            if (m_pending > 511) m_pending = 511;
        end else begin
            if (st) begin
                m_state = 1; m_pending = 0;
                m_level = (m_level == 15) ? 1 : m_level + 1;
            end
        end
        @(posedge frame_clk); #1;
        check("busy", {23'd0, bus.busy}, {23'd0, (m_pending != 0)});
        check("level", {20'd0, bus.level}, 24'(m_level));
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        #1;
        check("rst_score", bus.score_bcd, 24'h000000);
        check("rst_high", bus.high_score_bcd, 24'h000000);
        check("rst_level", {20'd0, bus.level}, 24'h000000);
        check("rst_clear", {23'd0, bus.level_clear}, 24'h000000);
        check("rst_busy", {23'd0, bus.busy}, 24'h000000);
        exp_score_q.delete(); exp_high_q.delete(); clr_q.delete();
        m_state = 0; m_pending = 0; m_score = 0; m_high = 0; m_level = 0;
        bus.start = 1'b0; bus.points = '0; bus.food_on = '1;
        repeat (2) @(posedge frame_clk);
        #1;
        Reset = 1'b1;
    endtask

    // Monitor: every visible output change is matched against the scoreboard.
    logic [23:0] last_score = 24'h000000;
    logic [23:0] last_high  = 24'h000000;
    always @(negedge frame_clk) begin
        if (Reset !== 1'b1) begin
            last_score = 24'h000000;
            last_high  = 24'h000000;
        end else begin
            if (bus.score_bcd !== last_score) begin
                if (exp_score_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL score_unexpected: got %h, expected %h", bus.score_bcd, last_score);
                end else begin
                    check("score_seq", bus.score_bcd, exp_score_q.pop_front());
                end
                last_score = bus.score_bcd;
            end
            if (bus.high_score_bcd !== last_high) begin
                if (exp_high_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL high_unexpected: got %h, expected %h", bus.high_score_bcd, last_high);
                end else begin
                    check("high_seq", bus.high_score_bcd, exp_high_q.pop_front());
                end
                last_high = bus.high_score_bcd;
            end
            if (bus.level_clear === 1'b1) begin
                if (clr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL clear_unexpected: got level_clear=1, expected 0");
                end else begin
                    check("clear_level", {20'd0, bus.level}, 24'(clr_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [NF-1:0] pts;
        Reset = 1'b0;
        bus.start = 1'b0; bus.points = '0; bus.food_on = '1;
        sbus.start = 1'b0; sbus.points = 4'd0; sbus.food_on = 4'hF;
        #2;
        do_reset();

        // Single pellet after start.
        step(1'b1, '0, '1);
        step(1'b0, 64'd1, '1);
        step(1'b0, '0, '1);
        check("single_pellet", bus.score_bcd, 24'h000010);
        step(1'b0, '0, '1);

        // Five pellets in one cycle drain over five cycles.
        do_reset();
        step(1'b1, '0, '1);
        step(1'b0, 64'h8000_0100_0010_1001, '1);
        repeat (5) step(1'b0, '0, '1);
        check("five_pellets", bus.score_bcd, 24'h000050);

        // Last three pellets eaten as food empties.
        step(1'b0, 64'h7, '0);
        repeat (5) step(1'b0, '0, '0);
        check("last_pellets", bus.score_bcd, 24'h000080);
        check("clear_seen", 24'(clr_q.size()), 24'd0);
        step(1'b1, 64'hF0, '0);
        check("level_two", {20'd0, bus.level}, 24'h000002);
        check("score_kept", bus.score_bcd, 24'h000080);

        // Randomized games, including a pending burst, mid-game reset and level wrap.
        for (int g = 0; g < 18; g++) begin
            if (m_state != 1) step(1'b1, rand_pts(8), rand_food());
            for (int c = 0; c < 20; c++) begin
                pts = (g == 3 && c < 10) ? '1 : rand_pts(16);
                step(($urandom_range(7) == 0), pts, rand_food());
                if (g == 8 && c == 10) do_reset();
            end
            step(1'b0, rand_pts(16), '0);
            n = 0;
            while (m_state == 1 && n < 2000) begin
                step(1'b0, '0, '0);
                n++;
            end
            repeat (3) step(1'b0, rand_pts(4), rand_food());
        end

        // Reset while credits are pending, then pellets without a start.
        do_reset();
        step(1'b1, '0, '1);
        step(1'b0, 64'h7F, '1);
        check("pending7_busy", {23'd0, bus.busy}, 24'h000001);
        do_reset();
        repeat (10) step(1'b0, rand_pts(4), rand_food());
        check("no_start_score", bus.score_bcd, 24'h000000);

        // Game ends at 120; next level keeps score and high score.
        step(1'b1, '0, '1);
        step(1'b0, 64'hFFF, '1);
        repeat (13) step(1'b0, '0, '1);
        step(1'b0, '0, '0);
        step(1'b0, '0, '0);
        check("g1_score", bus.score_bcd, 24'h000120);
        check("g1_high", bus.high_score_bcd, 24'h000120);
        step(1'b1, '0, '1);
        check("g2_high_kept", bus.high_score_bcd, 24'h000120);
        check("g2_score_kept", bus.score_bcd, 24'h000120);
        step(1'b0, 64'h3, '1);
        repeat (3) step(1'b0, '0, '1);
        check("g2_score", bus.score_bcd, 24'h000140);
        check("g2_high", bus.high_score_bcd, 24'h000140);
        do_reset();
        check("queues_empty", 24'(exp_score_q.size() + exp_high_q.size() + clr_q.size()), 24'd0);

        // Score saturation on a second instance with a large pellet value.
        sbus.start = 1'b1;
        @(posedge frame_clk); #1;
        sbus.start  = 1'b0;
        sbus.points = 4'b0001;
        repeat (10309) begin @(posedge frame_clk); #1; end
        sbus.points = 4'b0000;
        repeat (3) begin @(posedge frame_clk); #1; end
        check("sat_preload", sbus.score_bcd, to_bcd(SPV * 10309));
        sbus.points = 4'b0011;
        @(posedge frame_clk); #1;
        sbus.points = 4'b0000;
        repeat (4) begin @(posedge frame_clk); #1; end
        check("sat_score", sbus.score_bcd, 24'h999999);
        check("sat_busy", {23'd0, sbus.busy}, 24'h000000);
        check("sat_high", sbus.high_score_bcd, 24'h999999);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
